// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the stack memory responder and its storage array:
//   - mem_state_e : responder FSM states (IDLE / WAIT / RESP)
//   - DEF_ADDR_W  : default word-address width
//   - DEF_DATA_W  : default data word width
//   - WAIT_CNT_W  : width of the wait-state counter (covers 0..15 wait cycles)
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/stack_mem_array.sv
// -----------------------------------------------------------------------------
// stack_mem_array
// 2^ADDR_W x DATA_W storage with one synchronous write port and one registered
// read port. The responder pulses rd_en_i only on the edge that enters its
// response state, so rdata_o holds the captured word for the whole response.
// Contents are never cleared.
//
// Ports:
//   clock    in   system clock
//   wr_en_i  in   write addr_i with wdata_i on this edge
//   rd_en_i  in   capture mem[addr_i] into the read register on this edge
//   addr_i   in   ADDR_W word address shared by both ports
//   wdata_i  in   DATA_W write data
//   rdata_o  out  DATA_W registered read data
// -----------------------------------------------------------------------------
module stack_mem_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_mem_responder.sv
// -----------------------------------------------------------------------------
// stack_mem_responder
// Single-outstanding memory responder for a CPU stack. A request is accepted
// in IDLE, optionally waits WAIT_CYC cycles, then presents one response that
// is held until the initiator consumes it. Transactions are fully serialized.
//
// Optional feature (macro STACK_BOUNDS_CHECK_EN):
//   defined   - addresses outside STACK_LO..STACK_HI complete with normal
//               timing, resp_err=1, resp_rdata=0 and no array write.
//   undefined - resp_err is always 0 and every address reaches the array.
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   req_valid   in   request present
//   req_write   in   1 = write, 0 = read
//   req_addr    in   ADDR_W word address (used as given, never modified)
//   req_wdata   in   DATA_W write data
//   req_ready   out  high only in IDLE
//   resp_valid  out  high throughout the response state
//   resp_ready  in   initiator consumes the response
//   resp_rdata  out  DATA_W read data, 0 for writes and errored accesses
//   resp_err    out  access rejected by the bounds check
// -----------------------------------------------------------------------------
module stack_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                WAIT_CYC = 1,
    parameter logic [ADDR_W-1:0] STACK_LO = 8'h80,
    parameter logic [ADDR_W-1:0] STACK_HI = 8'hFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    // Counter value on the last wait cycle; unused when WAIT_CYC is 0.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

    mem_state_e            state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic                  write_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic                  resp_data_q;   // response carries array read data

    logic                  accept;
    logic                  wait_done;
    logic                  enter_resp;
    logic                  acc_write;
    logic [ADDR_W-1:0]     acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic                  acc_in_bounds;
    logic                  arr_wr_en;
    logic                  arr_rd_en;
    logic [DATA_W-1:0]     arr_rdata;

    assign accept    = req_valid && (state_q == ST_IDLE) && !reset;
    assign wait_done = (state_q == ST_WAIT) && (wait_cnt_q == WAIT_LAST);

    // With zero wait states the response state is entered on the accept edge
    // itself, before the request registers are loaded, so the live request
    // fields drive the array on that edge.
    assign enter_resp = !reset && (((WAIT_CYC == 0) && accept) || wait_done);
    assign acc_write  = (state_q == ST_IDLE) ? req_write : write_q;
    assign acc_addr   = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata  = (state_q == ST_IDLE) ? req_wdata : wdata_q;

`ifdef STACK_BOUNDS_CHECK_EN
    // One extra MSB keeps the comparisons from being trivially constant when
    // a bound sits at the edge of the address range.
    assign acc_in_bounds = ({1'b0, acc_addr} >= {1'b0, STACK_LO}) &&
                           ({1'b0, acc_addr} <= {1'b0, STACK_HI});
`else
    logic unused_bounds;
    assign unused_bounds = ^{STACK_LO, STACK_HI};
    assign acc_in_bounds = 1'b1;
`endif

    assign arr_wr_en = enter_resp &&  acc_write && acc_in_bounds;
    assign arr_rd_en = enter_resp && !acc_write && acc_in_bounds;

    stack_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock   (clock),
        .wr_en_i (arr_wr_en),
        .rd_en_i (arr_rd_en),
        .addr_i  (acc_addr),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wait_cnt_q  <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        state_q <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= !acc_in_bounds;
                resp_data_q  <= !acc_write && acc_in_bounds;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_data_q ? arr_rdata : '0;

endmodule

// File: tb/tb_stack_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_stack_mem_responder
// Three responders (WAIT_CYC = 0, 1, 3) driven by directed sequences and then
// randomized traffic. A transaction-level model predicts, for every cycle,
// whether each responder is ready or holding a response and what that
// response must contain; a compare process checks it on every falling edge.
// -----------------------------------------------------------------------------
module tb_stack_mem_responder;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid  [N];
    logic          req_write  [N];
    logic [AW-1:0] req_addr   [N];
    logic [DW-1:0] req_wdata  [N];
    logic          req_ready  [N];
    logic          resp_valid [N];
    logic          resp_ready [N];
    logic [DW-1:0] resp_rdata [N];
    logic          resp_err   [N];

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        stack_mem_responder #(
            .ADDR_W   (AW),
            .DATA_W   (DW),
            .WAIT_CYC ((gi == 0) ? 0 : ((gi == 1) ? 1 : 3)),
            .STACK_LO (8'h80),
            .STACK_HI (8'hFF)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .req_valid  (req_valid[gi]),
            .req_write  (req_write[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .req_ready  (req_ready[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_ready (resp_ready[gi]),
            .resp_rdata (resp_rdata[gi]),
            .resp_err   (resp_err[gi])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endfunction

    function automatic int wc_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    function automatic bit in_range(input logic [AW-1:0] a);
        return !BC || (a >= 8'h80);
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 8))
            0: return 8'h10;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'h81;
            4: return 8'h90;
            5: return 8'hC3;
            6: return 8'hF0;
            7: return 8'hFF;
            default: return AW'($urandom);
        endcase
    endfunction

    // ---------------- transaction-level reference model ----------------
    // One outstanding transaction per responder: accepted on edge a, resolved
    // (write committed / read value fixed) on edge a+WAIT_CYC, visible until
    // the edge where resp_ready is high; reset abandons anything unresolved.
    bit            started = 1'b0;
    int            edge_n  = 0;
    bit            m_busy  [N];
    bit            m_resp  [N];
    bit            m_write [N];
    bit            m_err   [N];
    bit            m_known [N];
    int            m_due   [N];
    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_wdata [N];
    logic [DW-1:0] m_rdata [N];
    logic [DW-1:0] mm      [N][256];
    bit            mk      [N][256];

    function automatic void resolve(input int i);
        m_resp[i] = 1'b1;
        m_err[i]  = !in_range(m_addr[i]);
        if (m_err[i]) begin
            m_rdata[i] = '0;
            m_known[i] = 1'b1;
        end else if (m_write[i]) begin
            mm[i][m_addr[i]] = m_wdata[i];
            mk[i][m_addr[i]] = 1'b1;
            m_rdata[i] = '0;
            m_known[i] = 1'b1;
        end else begin
            m_rdata[i] = mm[i][m_addr[i]];
            m_known[i] = mk[i][m_addr[i]];
        end
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_resp[i] = 1'b0;
            for (int a = 0; a < 256; a++) mk[i][a] = 1'b0;
        end
        forever begin
            @(posedge clock);
            edge_n++;
            for (int i = 0; i < N; i++) begin
                if (reset) begin
                    m_busy[i] = 1'b0;
                    m_resp[i] = 1'b0;
                end else if (m_busy[i]) begin
                    if (m_resp[i]) begin
                        if (resp_ready[i]) begin
                            m_busy[i] = 1'b0;
                            m_resp[i] = 1'b0;
                        end
                    end else if (edge_n == m_due[i]) begin
                        resolve(i);
                    end
                end else if (req_valid[i]) begin
                    m_busy[i]  = 1'b1;
                    m_write[i] = req_write[i];
                    m_addr[i]  = req_addr[i];
                    m_wdata[i] = req_wdata[i];
                    m_due[i]   = edge_n + wc_of(i);
                    if (wc_of(i) == 0) resolve(i);
                end
            end
            if (reset) started = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("req_ready[%0d] @%0d", i, edge_n), 32'(req_ready[i]), 32'(!m_busy[i]));
                    chk($sformatf("resp_valid[%0d] @%0d", i, edge_n), 32'(resp_valid[i]), 32'(m_busy[i] && m_resp[i]));
                    if (m_busy[i] && m_resp[i]) begin
                        chk($sformatf("resp_err[%0d] @%0d", i, edge_n), 32'(resp_err[i]), 32'(m_err[i]));
                        if (m_known[i])
                            chk($sformatf("resp_rdata[%0d] @%0d", i, edge_n), 32'(resp_rdata[i]), 32'(m_rdata[i]));
                    end
                end
            end
        end
    end

    // ---------------- directed transaction helper ----------------
    // Issues one request, scrambles the request lines right after accept,
    // holds resp_ready low for 'hold' extra cycles once the response shows,
    // then completes the handshake.
    task automatic txn(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int hold, output logic [DW-1:0] rd, output logic er,
                       output int lat, output int rl);
        int budget;
        rd = '0; er = 1'b0; lat = 0; rl = 0;
        req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
        resp_ready[i] = 1'b0; req_valid[i] = 1'b1;
        budget = 0;
        while (req_ready[i] !== 1'b1 && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        chk($sformatf("txn_ready_seen[%0d]", i), 32'(req_ready[i]), 32'd1);
        if (req_ready[i] !== 1'b1) begin
            req_valid[i] = 1'b0;
            return;
        end
        @(negedge clock);
        req_valid[i] = 1'b0; req_write[i] = !wr; req_addr[i] = ~a; req_wdata[i] = ~d;
        lat = 1;
        forever begin
            if (req_ready[i] === 1'b0) rl++;
            if (resp_valid[i] === 1'b1 || lat >= 40) break;
            @(negedge clock);
            lat++;
        end
        chk($sformatf("txn_valid_seen[%0d]", i), 32'(resp_valid[i]), 32'd1);
        if (resp_valid[i] !== 1'b1) return;
        rd = resp_rdata[i];
        er = resp_err[i];
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            if (req_ready[i] === 1'b0) rl++;
            chk($sformatf("hold_valid[%0d]", i), 32'(resp_valid[i]), 32'd1);
            chk($sformatf("hold_rdata[%0d]", i), 32'(resp_rdata[i]), 32'(rd));
            chk($sformatf("hold_err[%0d]", i), 32'(resp_err[i]), 32'(er));
        end
        resp_ready[i] = 1'b1;
        @(negedge clock);
        resp_ready[i] = 1'b0;
        chk($sformatf("idle_after[%0d]", i), 32'(req_ready[i]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            lat, rl, n_rdy, n_val;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   resp_ready[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
            chk($sformatf("rst_valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", i), 32'(resp_rdata[i]), 32'd0);
            chk($sformatf("rst_err[%0d]", i), 32'(resp_err[i]), 32'd0);
        end

        // Write then read back with one wait state and a slow consumer.
        txn(1, 1'b1, 8'hF0, 16'hBEEF, 1, rd, er, lat, rl);
        chk("w_beef_latency", 32'(lat), 32'd2);
        chk("w_beef_ready_low", 32'(rl), 32'd3);
        chk("w_beef_err", 32'(er), 32'd0);
        txn(1, 1'b0, 8'hF0, 16'h0000, 4, rd, er, lat, rl);
        chk("r_beef_data", 32'(rd), 32'hBEEF);
        chk("r_beef_err", 32'(er), 32'd0);
        chk("r_beef_latency", 32'(lat), 32'd2);

        // Three wait states; request lines scrambled during WAIT.
        txn(2, 1'b1, 8'hC3, 16'h1357, 0, rd, er, lat, rl);
        chk("w3_latency", 32'(lat), 32'd4);
        txn(2, 1'b0, 8'hC3, 16'hFFFF, 0, rd, er, lat, rl);
        chk("r3_latched_data", 32'(rd), 32'h1357);
        txn(2, 1'b0, 8'h3C, 16'h0000, 0, rd, er, lat, rl);
        chk("r3_scrambled_err", 32'(er), 32'(!in_range(8'h3C)));

        // Bounds: low address rejected only when the check is built in.
        txn(1, 1'b1, 8'h10, 16'h1234, 0, rd, er, lat, rl);
        chk("b_wr_err", 32'(er), 32'(BC));
        txn(1, 1'b0, 8'h10, 16'h0000, 0, rd, er, lat, rl);
        chk("b_rd_err", 32'(er), 32'(BC));
        chk("b_rd_data", 32'(rd), BC ? 32'd0 : 32'h1234);
        txn(1, 1'b0, 8'h80, 16'h0000, 0, rd, er, lat, rl);
        chk("b_80_err", 32'(er), 32'd0);

        // Zero wait states, back-to-back with req_valid and resp_ready high.
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h81;
        req_wdata[0] = 16'h0F0F; resp_ready[0] = 1'b1;
        n_rdy = 0; n_val = 0;
        repeat (20) begin
            @(negedge clock);
            if (req_ready[0] === 1'b1) n_rdy++;
            if (resp_valid[0] === 1'b1) n_val++;
        end
        req_valid[0] = 1'b0;
        @(negedge clock);
        resp_ready[0] = 1'b0;
        chk("b2b_responses", 32'(n_val), 32'd10);
        chk("b2b_ready_cycles", 32'(n_rdy), 32'd10);

        // Reset during WAIT abandons an uncommitted write.
        txn(1, 1'b1, 8'h90, 16'hAAAA, 0, rd, er, lat, rl);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 8'h90; req_wdata[1] = 16'h5555;
        @(negedge clock);
        chk("abort_accepted", 32'(req_ready[1]), 32'd0);
        req_valid[1] = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_rst_ready", 32'(req_ready[1]), 32'd1);
        chk("abort_rst_valid", 32'(resp_valid[1]), 32'd0);
        chk("abort_rst_rdata", 32'(resp_rdata[1]), 32'd0);
        chk("abort_rst_err", 32'(resp_err[1]), 32'd0);
        @(negedge clock);
        chk("abort_ready_after", 32'(req_ready[1]), 32'd1);
        txn(1, 1'b0, 8'h90, 16'h0000, 0, rd, er, lat, rl);
        chk("abort_readback", 32'(rd), 32'hAAAA);

        // Randomized traffic, including stray req/resp signals and resets.
        repeat (3000) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                req_valid[i]  = ($urandom_range(0, 3) != 0);
                req_write[i]  = 1'($urandom_range(0, 1));
                req_addr[i]   = pick_addr();
                req_wdata[i]  = DW'($urandom);
                resp_ready[i] = 1'($urandom_range(0, 1));
            end
            reset = ($urandom_range(0, 149) == 0);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; resp_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_mem_responder.md
STACK_MEM_RESPONDER -- requirements
Module: stack_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width in words.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter WAIT_CYC, default 1, wait states between accept and response (0..15).
REQ-004 Parameter STACK_LO, default 8'h80, lowest legal address when bounds check is compiled in.
REQ-005 Parameter STACK_HI, default 8'hFF, highest legal address when bounds check is compiled in.
REQ-006 clock  in  1  system clock; reset reset, synchronous, active-high; clock clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 req_valid  in  1  initiator presents a request.
REQ-009 req_write  in  1  1 = write, 0 = read; qualified by req_valid.
REQ-010 req_addr  in  ADDR_W  word address, e.g. SP or SP-updated.
REQ-011 req_wdata  in  DATA_W  write data, e.g. register or PC.
REQ-012 req_ready  out  1  responder can accept a request this cycle.
REQ-013 resp_valid  out  1  response available.
REQ-014 resp_ready  in  1  initiator consumes the response.
REQ-015 resp_rdata  out  DATA_W  read data; 0 for writes and errored accesses.
REQ-016 resp_err  out  1  access rejected by the bounds check.

Function
REQ-017 FSM states: IDLE, WAIT, RESP.
REQ-018 req_ready is 1 only in IDLE; a request is accepted on a rising clock edge with req_valid && req_ready.
REQ-019 On accept, addr, write flag and wdata are latched; later changes to req_* have no effect.
REQ-020 IDLE->WAIT on accept when WAIT_CYC>0; IDLE->RESP on accept when WAIT_CYC=0.
REQ-021 WAIT counts WAIT_CYC cycles, then enters RESP; the response is valid exactly WAIT_CYC+1 cycles after the accept edge.
REQ-022 The write commits to the array, and read data is captured, on the edge entering RESP.
REQ-023 resp_valid is 1 throughout RESP; resp_rdata and resp_err stay stable until resp_valid && resp_ready.
REQ-024 RESP->IDLE on resp_valid && resp_ready; no new request is accepted in that same cycle (minimum 1 idle cycle between transactions).
REQ-025 Transactions are strictly serialized; a read after a write to the same address returns the written data.
REQ-026 Address arithmetic is performed by the initiator; no wrap or increment occurs here; every address in 0..2^ADDR_W-1 is decoded.
REQ-027 resp_ready asserted outside RESP is ignored; req_valid outside IDLE is ignored and not queued.

Reset
REQ-028 Reset forces state IDLE, wait counter 0, req_ready=1 on the cycle after reset deasserts, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-029 Reset mid-transaction abandons it; a write not yet committed (REQ-022) is not committed.
REQ-030 Array contents are not cleared by reset.

Configuration
REQ-031 Macro STACK_BOUNDS_CHECK_EN defined: an access with addr<STACK_LO or addr>STACK_HI completes with normal timing, resp_err=1, resp_rdata=0, and no array write.
REQ-032 Macro STACK_BOUNDS_CHECK_EN undefined: resp_err is tied 0, STACK_LO and STACK_HI are unused, and all addresses access the array.

Structure
REQ-033 Shared package cpu_mem_pkg holds the FSM state enum (IDLE/WAIT/RESP), ADDR_W/DATA_W defaults, and the wait-counter width constant.
REQ-034 Sub-module stack_mem_array: 2^ADDR_W x DATA_W, one synchronous write port, one read port sampled on the RESP-entry edge.

Verification
REQ-035 Reset, then write 16'hBEEF to 8'hF0 with WAIT_CYC=1 -> req_ready=0 for 3 cycles, resp_valid on the 2nd edge after accept, resp_err=0.
REQ-036 Read 8'hF0 after REQ-035 -> resp_rdata=16'hBEEF; hold resp_ready=0 for 4 cycles -> data and valid stable, then one handshake -> IDLE.
REQ-037 WAIT_CYC=0, back-to-back requests with req_valid held high -> responses 1 cycle after each accept; accepts no closer than every 2 cycles.
REQ-038 With STACK_BOUNDS_CHECK_EN, write 16'h1234 to 8'h10, then read 8'h10 -> both resp_err=1, read resp_rdata=0; read of 8'h80 -> resp_err=0.
REQ-039 Write 16'hAAAA to 8'h90, completed; then write 16'h5555 to 8'h90, asserting reset during WAIT; then read 8'h90 -> 16'hAAAA, and outputs match reset values on the cycle after reset.
REQ-040 Change req_addr and req_wdata during WAIT -> the response reflects the values latched at accept.
